// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register for the 5-stage RV32I core.
// Captures the decoded control bundle, operands, immediate and register indices,
// detects load-use hazards against the instruction currently in EX, and inserts
// a bubble on stall or on an EX redirect flush.
// Optional macro ID_EX_PERF_CNT_EN adds saturating stall/flush event counters.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_valid_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_write_i,
  input  logic              id_mem_read_i,
  input  logic [4:0]        id_alu_op_i,
  input  logic [4:0]        id_npc_op_i,
  input  logic              id_alu_src_i,
  input  logic [1:0]        id_wd_sel_i,
  input  logic [2:0]        id_funct3_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   id_rd1_i,
  input  logic [XLEN-1:0]   id_rd2_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic              flush_i,
  output logic              stall_o,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]       perf_stall_cnt_o,
  output logic [31:0]       perf_flush_cnt_o,
`endif
  output logic              ex_valid_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_write_o,
  output logic              ex_mem_read_o,
  output logic              ex_alu_src_o,
  output logic [4:0]        ex_alu_op_o,
  output logic [4:0]        ex_npc_op_o,
  output logic [1:0]        ex_wd_sel_o,
  output logic [2:0]        ex_funct3_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_rd1_o,
  output logic [XLEN-1:0]   ex_rd2_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [REG_AW-1:0] ex_rs1_o,
  output logic [REG_AW-1:0] ex_rs2_o,
  output logic [REG_AW-1:0] ex_rd_o
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_write;
    logic              mem_read;
    logic              alu_src;
    logic [4:0]        alu_op;
    logic [4:0]        npc_op;
    logic [1:0]        wd_sel;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } ex_bundle_t;

  ex_bundle_t ex_d, ex_q;
  logic       load_use;

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  always_comb begin
    load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
               ((id_rs1_used_i & (id_rs1_i == ex_q.rd)) |
                (id_rs2_used_i & (id_rs2_i == ex_q.rd)));
    stall_o  = id_valid_i & load_use & ~flush_i;
  end

  // Next EX contents: bubble on flush/stall, otherwise capture ID with side effects gated by valid.
  always_comb begin
    ex_d = '0;
    if (!flush_i && !stall_o) begin
      ex_d.valid     = id_valid_i;
      ex_d.reg_write = id_valid_i & id_reg_write_i;
      ex_d.mem_write = id_valid_i & id_mem_write_i;
      ex_d.mem_read  = id_valid_i & id_mem_read_i;
      ex_d.npc_op    = id_valid_i ? id_npc_op_i : '0;
      ex_d.alu_src   = id_alu_src_i;
      ex_d.alu_op    = id_alu_op_i;
      ex_d.wd_sel    = id_wd_sel_i;
      ex_d.funct3    = id_funct3_i;
      ex_d.pc        = id_pc_i;
      ex_d.rd1       = id_rd1_i;
      ex_d.rd2       = id_rd2_i;
      ex_d.imm       = id_imm_i;
      ex_d.rs1       = id_rs1_i;
      ex_d.rs2       = id_rs2_i;
      ex_d.rd        = id_rd_i;
    end
  end

  // Pipeline register; reset leaves a bubble in EX.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ex_valid_o     = ex_q.valid;
  assign ex_reg_write_o = ex_q.reg_write;
  assign ex_mem_write_o = ex_q.mem_write;
  assign ex_mem_read_o  = ex_q.mem_read;
  assign ex_alu_src_o   = ex_q.alu_src;
  assign ex_alu_op_o    = ex_q.alu_op;
  assign ex_npc_op_o    = ex_q.npc_op;
  assign ex_wd_sel_o    = ex_q.wd_sel;
  assign ex_funct3_o    = ex_q.funct3;
  assign ex_pc_o        = ex_q.pc;
  assign ex_rd1_o       = ex_q.rd1;
  assign ex_rd2_o       = ex_q.rd2;
  assign ex_imm_o       = ex_q.imm;
  assign ex_rs1_o       = ex_q.rs1;
  assign ex_rs2_o       = ex_q.rs2;
  assign ex_rd_o        = ex_q.rd;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] flush_cnt_d, flush_cnt_q;

  // Saturating event counters for stall and flush cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush_i && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven and randomized self-checking bench for id_ex_stage.
module tb_id_ex_stage;

  localparam logic [4:0] ALU_ADD = 5'd1;
  localparam logic [4:0] NPC_JAL = 5'd2;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        mw;
    logic        mr;
    logic [4:0]  alu_op;
    logic [4:0]  npc_op;
    logic        alu_src;
    logic [1:0]  wd_sel;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1u;
    logic        rs2u;
  } id_in_t;

  typedef struct {
    id_in_t      in;
    logic        flush;
    logic        e_stall;
    logic        e_valid;
    logic        e_rw;
    logic        e_mw;
    logic        e_mr;
    logic        e_src;
    logic [4:0]  e_npc;
    logic [4:0]  e_rd;
    logic [31:0] e_imm;
    logic        care;
  } vec_t;

  logic        clk, rstn;
  logic        id_valid_i, id_reg_write_i, id_mem_write_i, id_mem_read_i;
  logic [4:0]  id_alu_op_i, id_npc_op_i;
  logic        id_alu_src_i;
  logic [1:0]  id_wd_sel_i;
  logic [2:0]  id_funct3_i;
  logic [31:0] id_pc_i, id_rd1_i, id_rd2_i, id_imm_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_rs1_used_i, id_rs2_used_i, flush_i;
  logic        stall_o;
  logic        ex_valid_o, ex_reg_write_o, ex_mem_write_o, ex_mem_read_o, ex_alu_src_o;
  logic [4:0]  ex_alu_op_o, ex_npc_op_o;
  logic [1:0]  ex_wd_sel_o;
  logic [2:0]  ex_funct3_o;
  logic [31:0] ex_pc_o, ex_rd1_o, ex_rd2_o, ex_imm_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_stall_cnt_o, perf_flush_cnt_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tab[$];

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rstn(rstn),
    .id_valid_i(id_valid_i), .id_reg_write_i(id_reg_write_i),
    .id_mem_write_i(id_mem_write_i), .id_mem_read_i(id_mem_read_i),
    .id_alu_op_i(id_alu_op_i), .id_npc_op_i(id_npc_op_i),
    .id_alu_src_i(id_alu_src_i), .id_wd_sel_i(id_wd_sel_i),
    .id_funct3_i(id_funct3_i), .id_pc_i(id_pc_i),
    .id_rd1_i(id_rd1_i), .id_rd2_i(id_rd2_i), .id_imm_i(id_imm_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .flush_i(flush_i), .stall_o(stall_o),
`ifdef ID_EX_PERF_CNT_EN
    .perf_stall_cnt_o(perf_stall_cnt_o), .perf_flush_cnt_o(perf_flush_cnt_o),
`endif
    .ex_valid_o(ex_valid_o), .ex_reg_write_o(ex_reg_write_o),
    .ex_mem_write_o(ex_mem_write_o), .ex_mem_read_o(ex_mem_read_o),
    .ex_alu_src_o(ex_alu_src_o), .ex_alu_op_o(ex_alu_op_o),
    .ex_npc_op_o(ex_npc_op_o), .ex_wd_sel_o(ex_wd_sel_o),
    .ex_funct3_o(ex_funct3_o), .ex_pc_o(ex_pc_o),
    .ex_rd1_o(ex_rd1_o), .ex_rd2_o(ex_rd2_o), .ex_imm_o(ex_imm_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic id_in_t instr(input logic v, rw, mw, mr, input logic [4:0] alu, npc,
                                   input logic src, input logic [1:0] wd, input logic [2:0] f3,
                                   input logic [4:0] rs1, rs2, rd, input logic u1, u2,
                                   input logic [31:0] imm);
    id_in_t x;
    x = '0;
    x.valid = v; x.rw = rw; x.mw = mw; x.mr = mr; x.alu_op = alu; x.npc_op = npc;
    x.alu_src = src; x.wd_sel = wd; x.f3 = f3; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd;
    x.rs1u = u1; x.rs2u = u2; x.imm = imm;
    x.rd1 = 32'h1000_0000 | 32'(rs1); x.rd2 = 32'h2000_0000 | 32'(rs2);
    return x;
  endfunction

  task automatic add_vec(input id_in_t in, input logic fl, st, v, rw, mw, mr, src,
                         input logic [4:0] npc, rd, input logic [31:0] imm, input logic care);
    vec_t t;
    t.in = in;
    t.in.pc = 32'h0000_1000 + 32'(4 * tab.size());
    t.flush = fl; t.e_stall = st; t.e_valid = v; t.e_rw = rw; t.e_mw = mw; t.e_mr = mr;
    t.e_src = src; t.e_npc = npc; t.e_rd = rd; t.e_imm = imm; t.care = care;
    tab.push_back(t);
  endtask

  task automatic drive(input id_in_t x, input logic fl);
    id_valid_i = x.valid; id_reg_write_i = x.rw; id_mem_write_i = x.mw; id_mem_read_i = x.mr;
    id_alu_op_i = x.alu_op; id_npc_op_i = x.npc_op; id_alu_src_i = x.alu_src;
    id_wd_sel_i = x.wd_sel; id_funct3_i = x.f3; id_pc_i = x.pc; id_rd1_i = x.rd1;
    id_rd2_i = x.rd2; id_imm_i = x.imm; id_rs1_i = x.rs1; id_rs2_i = x.rs2; id_rd_i = x.rd;
    id_rs1_used_i = x.rs1u; id_rs2_used_i = x.rs2u; flush_i = fl;
  endtask

  task automatic step(input id_in_t x, input logic fl);
    drive(x, fl);
    @(posedge clk);
    #1;
  endtask

  // Releases reset between clock edges with an idle (invalid) ID slot.
  task automatic release_reset();
    drive('0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic id_in_t rand_instr();
    id_in_t x;
    x.valid = ($urandom_range(0, 7) != 0);
    x.mr = ($urandom_range(0, 2) == 0);
    x.rw = 1'($urandom);
    x.mw = !x.mr && 1'($urandom);
    x.alu_op = 5'($urandom); x.npc_op = 5'($urandom); x.alu_src = 1'($urandom);
    x.wd_sel = 2'($urandom); x.f3 = 3'($urandom); x.pc = $urandom; x.rd1 = $urandom;
    x.rd2 = $urandom; x.imm = $urandom;
    x.rs1 = 5'($urandom_range(0, 3)); x.rs2 = 5'($urandom_range(0, 3));
    x.rd = 5'($urandom_range(0, 3));
    x.rs1u = 1'($urandom); x.rs2u = 1'($urandom);
    return x;
  endfunction

  initial begin
    id_in_t lw_x5, lw_x0, lw_self, add656, add600, add_r2, addi734, addi101, sw, jal, bad, bad2;
    id_in_t cur, m;
    logic   mcare, held, fl, es;
    int     exp_stalls, exp_flushes;

    rstn = 1'b0;
    drive('0, 1'b0);
    #3;
    chk("rst_valid", ex_valid_o, 0);
    chk("rst_rw", ex_reg_write_o, 0);
    chk("rst_mw", ex_mem_write_o, 0);
    chk("rst_mr", ex_mem_read_o, 0);
    chk("rst_npc", ex_npc_op_o, 0);
    chk("rst_alu", ex_alu_op_o, 0);
    chk("rst_pc", ex_pc_o, 0);
    chk("rst_imm", ex_imm_o, 0);
    chk("rst_rd", ex_rd_o, 0);
    chk("rst_stall", stall_o, 0);
    release_reset();

    //                 v rw mw mr alu      npc     src wd f3 rs1 rs2 rd u1 u2 imm
    lw_x5   = instr(1, 1, 0, 1, ALU_ADD, 5'd0,   1, 1, 2, 1, 0, 5, 1, 0, 0);
    lw_x0   = instr(1, 1, 0, 1, ALU_ADD, 5'd0,   1, 1, 2, 1, 0, 0, 1, 0, 0);
    lw_self = instr(1, 1, 0, 1, ALU_ADD, 5'd0,   1, 1, 2, 5, 0, 5, 1, 0, 0);
    add656  = instr(1, 1, 0, 0, ALU_ADD, 5'd0,   0, 0, 0, 5, 2, 6, 1, 1, 0);
    add600  = instr(1, 1, 0, 0, ALU_ADD, 5'd0,   0, 0, 0, 0, 0, 6, 1, 1, 0);
    add_r2  = instr(1, 1, 0, 0, ALU_ADD, 5'd0,   0, 0, 0, 2, 5, 6, 1, 1, 0);
    addi734 = instr(1, 1, 0, 0, ALU_ADD, 5'd0,   1, 0, 0, 3, 5, 7, 1, 0, 4);
    addi101 = instr(1, 1, 0, 0, ALU_ADD, 5'd0,   1, 0, 0, 0, 0, 1, 1, 0, 1);
    sw      = instr(1, 0, 1, 0, ALU_ADD, 5'd0,   1, 0, 2, 2, 1, 0, 1, 1, 8);
    jal     = instr(1, 1, 0, 0, ALU_ADD, NPC_JAL, 0, 2, 0, 0, 0, 1, 0, 0, 16);
    bad     = instr(0, 1, 1, 1, ALU_ADD, 5'd3,   1, 1, 0, 1, 2, 9, 1, 1, 32'hdead);
    bad2    = instr(0, 0, 0, 0, 5'd0,    5'd0,   0, 0, 0, 5, 0, 0, 1, 0, 0);

    //          in       fl st v rw mw mr src npc      rd  imm care
    add_vec(lw_x5,   0, 0, 1, 1, 0, 1, 1, 5'd0,   5, 0,  1);
    add_vec(add656,  0, 1, 0, 0, 0, 0, 0, 5'd0,   0, 0,  1);
    add_vec(add656,  0, 0, 1, 1, 0, 0, 0, 5'd0,   6, 0,  1);
    add_vec(lw_x0,   0, 0, 1, 1, 0, 1, 1, 5'd0,   0, 0,  1);
    add_vec(add600,  0, 0, 1, 1, 0, 0, 0, 5'd0,   6, 0,  1);
    add_vec(lw_x5,   0, 0, 1, 1, 0, 1, 1, 5'd0,   5, 0,  1);
    add_vec(addi734, 0, 0, 1, 1, 0, 0, 1, 5'd0,   7, 4,  1);
    add_vec(lw_x5,   0, 0, 1, 1, 0, 1, 1, 5'd0,   5, 0,  1);
    add_vec(add656,  1, 0, 0, 0, 0, 0, 0, 5'd0,   0, 0,  1);
    add_vec(addi101, 0, 0, 1, 1, 0, 0, 1, 5'd0,   1, 1,  1);
    add_vec(sw,      0, 0, 1, 0, 1, 0, 1, 5'd0,   0, 8,  1);
    add_vec(jal,     0, 0, 1, 1, 0, 0, 0, NPC_JAL, 1, 16, 1);
    add_vec(bad,     0, 0, 0, 0, 0, 0, 0, 5'd0,   0, 0,  0);
    add_vec(lw_self, 0, 0, 1, 1, 0, 1, 1, 5'd0,   5, 0,  1);
    add_vec(bad2,    0, 0, 0, 0, 0, 0, 0, 5'd0,   0, 0,  0);
    add_vec(lw_self, 0, 0, 1, 1, 0, 1, 1, 5'd0,   5, 0,  1);
    add_vec(add_r2,  0, 1, 0, 0, 0, 0, 0, 5'd0,   0, 0,  1);
    add_vec(add_r2,  0, 0, 1, 1, 0, 0, 0, 5'd0,   6, 0,  1);

    foreach (tab[i]) begin
      drive(tab[i].in, tab[i].flush);
      #1;
      chk($sformatf("tab%0d_stall", i), stall_o, tab[i].e_stall);
      @(posedge clk);
      #1;
      chk($sformatf("tab%0d_valid", i), ex_valid_o, tab[i].e_valid);
      chk($sformatf("tab%0d_rw", i), ex_reg_write_o, tab[i].e_rw);
      chk($sformatf("tab%0d_mw", i), ex_mem_write_o, tab[i].e_mw);
      chk($sformatf("tab%0d_mr", i), ex_mem_read_o, tab[i].e_mr);
      chk($sformatf("tab%0d_npc", i), ex_npc_op_o, tab[i].e_npc);
      if (tab[i].care) begin
        chk($sformatf("tab%0d_src", i), ex_alu_src_o, tab[i].e_src);
        chk($sformatf("tab%0d_rd", i), ex_rd_o, tab[i].e_rd);
        chk($sformatf("tab%0d_imm", i), ex_imm_o, tab[i].e_imm);
        chk($sformatf("tab%0d_pc", i), ex_pc_o, tab[i].e_valid ? tab[i].in.pc : 32'd0);
      end
    end

`ifdef ID_EX_PERF_CNT_EN
    rstn = 1'b0;
    #1;
    release_reset();
    for (int k = 0; k < 3; k++) begin
      step(lw_x5, 1'b0);
      step(add656, 1'b0);
      step(add656, 1'b0);
    end
    step(addi101, 1'b1);
    step(addi101, 1'b1);
    chk("perf_stall3", perf_stall_cnt_o, 3);
    chk("perf_flush2", perf_flush_cnt_o, 2);
    step(addi101, 1'b0);
    chk("perf_pre_valid", ex_valid_o, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("perf_rst_stall", perf_stall_cnt_o, 0);
    chk("perf_rst_flush", perf_flush_cnt_o, 0);
    chk("perf_rst_valid", ex_valid_o, 0);
    release_reset();
`endif

    // Reset asserted while a load-use stall is being requested.
    step(lw_x5, 1'b0);
    drive(add656, 1'b0);
    #1;
    chk("mid_stall_pre", stall_o, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_stall_rst", stall_o, 0);
    chk("mid_valid_rst", ex_valid_o, 0);
    chk("mid_mr_rst", ex_mem_read_o, 0);
    release_reset();

    // Randomized run against a behavioural model of the EX slot.
    m = '0;
    mcare = 1'b0;
    held = 1'b0;
    cur = '0;
    exp_stalls = 0;
    exp_flushes = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!held) cur = rand_instr();
      fl = ($urandom_range(0, 7) == 0);
      drive(cur, fl);
      #1;
      es = cur.valid && m.valid && m.mr && (m.rd != 0) &&
           ((cur.rs1u && cur.rs1 == m.rd) || (cur.rs2u && cur.rs2 == m.rd)) && !fl;
      chk("rnd_stall", stall_o, es);
      if (es) exp_stalls++;
      if (fl) exp_flushes++;
      if (fl || es) begin
        m = '0;
        mcare = 1'b1;
      end else if (!cur.valid) begin
        m = '0;
        mcare = 1'b0;
      end else begin
        m = cur;
        mcare = 1'b1;
      end
      held = es;
      @(posedge clk);
      #1;
      chk("rnd_valid", ex_valid_o, m.valid);
      chk("rnd_rw", ex_reg_write_o, m.rw);
      chk("rnd_mw", ex_mem_write_o, m.mw);
      chk("rnd_mr", ex_mem_read_o, m.mr);
      chk("rnd_npc", ex_npc_op_o, m.npc_op);
      if (mcare) begin
        chk("rnd_alu", ex_alu_op_o, m.alu_op);
        chk("rnd_src", ex_alu_src_o, m.alu_src);
        chk("rnd_wd", ex_wd_sel_o, m.wd_sel);
        chk("rnd_f3", ex_funct3_o, m.f3);
        chk("rnd_pc", ex_pc_o, m.pc);
        chk("rnd_rd1", ex_rd1_o, m.rd1);
        chk("rnd_rd2", ex_rd2_o, m.rd2);
        chk("rnd_imm", ex_imm_o, m.imm);
        chk("rnd_rs1", ex_rs1_o, m.rs1);
        chk("rnd_rs2", ex_rs2_o, m.rs2);
        chk("rnd_rd", ex_rd_o, m.rd);
      end
    end
`ifdef ID_EX_PERF_CNT_EN
    chk("rnd_perf_stall", perf_stall_cnt_o, 64'(exp_stalls));
    chk("rnd_perf_flush", perf_flush_cnt_o, 64'(exp_flushes));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the 5-stage RV32I core. Sits directly downstream of the control decoder and register file.
- Captures the decoded control bundle (RegWrite, MemWrite, MemRead, ALUOp, NPCOp, ALUSrc, WDSel) plus the operands, immediate and register indices, and presents them to EX one cycle later.
- Contains load-use hazard detection (stall request to PC/IF-ID) and bubble insertion on stall or on redirect flush.

Parameters:
XLEN, 32, datapath width (PC, operands, immediate)
REG_AW, 5, register index width

Ports:
clk  in  1  core clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
id_valid_i  in  1  ID slot holds a real instruction
id_reg_write_i  in  1  decoder RegWrite
id_mem_write_i  in  1  decoder MemWrite
id_mem_read_i  in  1  decoder MemRead
id_alu_op_i  in  5  decoder ALUOp
id_npc_op_i  in  5  decoder NPCOp (branch bit is pre-Zero; EX resolves)
id_alu_src_i  in  1  decoder ALUSrc
id_wd_sel_i  in  2  decoder WDSel
id_funct3_i  in  3  instruction funct3 (branch/load/store width)
id_pc_i  in  XLEN  instruction PC
id_rd1_i, id_rd2_i  in  XLEN  register file read data
id_imm_i  in  XLEN  extended immediate
id_rs1_i, id_rs2_i, id_rd_i  in  REG_AW  register indices
id_rs1_used_i, id_rs2_used_i  in  1  instruction actually reads rs1/rs2
flush_i  in  1  EX-stage redirect (taken branch/jal/jalr)
stall_o  out  1  load-use stall request: hold PC and IF/ID
ex_valid_o  out  1  EX slot valid
ex_reg_write_o, ex_mem_write_o, ex_mem_read_o, ex_alu_src_o  out  1 each  registered controls
ex_alu_op_o, ex_npc_op_o  out  5 each  registered controls
ex_wd_sel_o  out  2  registered control
ex_funct3_o  out  3  registered funct3
ex_pc_o, ex_rd1_o, ex_rd2_o, ex_imm_o  out  XLEN  registered data
ex_rs1_o, ex_rs2_o, ex_rd_o  out  REG_AW  registered indices (for forwarding unit)

Behaviour:
- Reset (rstn low, asynchronous): every ex_* output is 0 and ex_valid_o is 0. EX holds a bubble.
- Hazard (combinational, zero latency): load_use = ex_valid_o & ex_mem_read_o & (ex_rd_o != 0) & ((id_rs1_used_i & id_rs1_i == ex_rd_o) | (id_rs2_used_i & id_rs2_i == ex_rd_o)).
  - stall_o = id_valid_i & load_use & ~flush_i.
- Per-cycle register update, priority order:
  1. flush_i = 1: load a bubble.
  2. Else stall_o = 1: load a bubble. ID content is held upstream and re-presented next cycle.
  3. Else: capture all id_* fields; ex_valid_o <= id_valid_i.
- Bubble: all ex_* fields 0, including ex_valid_o, write enables, ALUOp (nop) and NPCOp (PLUS4). A bubble must never write the register file or memory, and must never redirect.
- Invalid capture: if id_valid_i = 0, ex_valid_o = 0 and ex_reg_write_o, ex_mem_write_o, ex_mem_read_o and ex_npc_op_o are forced to 0. Data fields are don't-care.
- Latency: exactly one cycle ID to EX. A stall lasts exactly one cycle per load-use pair, because the load leaves EX the next cycle.
- rd = x0 never causes a stall. A load whose own rs1 equals its rd does not stall itself.
- Simultaneous flush and hazard: flush wins and stall_o = 0, since the stalled instruction is on the wrong path.
- Reset asserted mid-stall: stall_o drops immediately, because ex_valid_o clears asynchronously.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt_o (32) and perf_flush_cnt_o (32).
  - perf_stall_cnt_o increments on each cycle with stall_o = 1.
  - perf_flush_cnt_o increments on each cycle with flush_i = 1.
  - Both saturate at 0xFFFF_FFFF and reset to 0 on rstn.
- Undefined: ports and counters are absent, with no other behavioural change.

Test Plan:
- Reset release, then lw x5,0(x1) followed by add x6,x5,x2: stall_o = 1 for exactly one cycle, then EX shows a bubble (ex_valid_o = 0, ex_reg_write_o = 0), then the add is captured with ex_rd_o = 6.
- lw x0,0(x1) followed by add x6,x0,x0: stall_o stays 0, and the add reaches EX one cycle after the load.
- lw x5 followed by addi x7,x3,4 (rs2 field 5, id_rs2_used_i = 0): no stall.
- flush_i = 1 in the same cycle as a load-use hazard: stall_o = 0, EX loads a bubble, and ex_npc_op_o = 0 next cycle.
- Back-to-back addi x1,x0,1 / sw x1,8(x2): fields appear unchanged one cycle later (ex_imm_o = 8, ex_mem_write_o = 1, ex_alu_src_o = 1), and no stall.
- With ID_EX_PERF_CNT_EN: 3 load-use pairs and 2 flushes give perf_stall_cnt_o = 3 and perf_flush_cnt_o = 2. Asserting rstn low mid-run clears both counters to 0 and ex_valid_o to 0 immediately.
